// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Function codes and FSM state encoding for seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] FUNC_ADD = 2'b00;
  localparam logic [1:0] FUNC_SUB = 2'b01;
  localparam logic [1:0] FUNC_MUL = 2'b10;
  localparam logic [1:0] FUNC_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    DIV    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_alu_if.sv
// ============================================================================
// Module      : seq_alu_if
// Description : Start/done request bus between operand registers and seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_alu_if #(
  parameter int WIDTH = 6
);

  logic                 start;
  logic [1:0]           func;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   out;
  logic                 overflow;
  logic                 div_zero;

  modport master (
    output start, func, a, b,
    input  busy, done, out, overflow, div_zero
  );

  modport slave (
    input  start, func, a, b,
    output busy, done, out, overflow, div_zero
  );

endinterface

`default_nettype wire

// File: rtl/restoring_div_core.sv
// ============================================================================
// Module      : restoring_div_core
// Description : Unsigned WIDTH-step restoring divider, one quotient bit/step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_div_core #(
  parameter int WIDTH = 6
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  input  wire logic             i_start,
  input  wire logic             i_step,
  input  wire logic [WIDTH-1:0] i_dividend,
  input  wire logic [WIDTH-1:0] i_divisor,
  output logic                  o_finish,
  output logic [WIDTH-1:0]      o_quotient,
  output logic [WIDTH-1:0]      o_remainder
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_div;
  logic [c_cnt_w-1:0] r_cnt;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;

  // Partial remainder is always below the divisor, so the W+1-bit difference
  // carries a valid sign in its top bit.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};

  assign o_finish    = (r_cnt == c_cnt_w'(WIDTH));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= '0;
    end else if (i_step && !o_finish) begin
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Handshaked signed add/sub/mul/div with an iterative datapath.
//               Optional macro SEQ_ALU_EARLY_TERM_EN: multiply stops once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  wire logic  clock,
  input  wire logic  reset_n,
  seq_alu_if.slave   bus
);

  localparam int               c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] c_min   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               r_state;
  logic [1:0]           r_func;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_out;
  logic                 r_ovf;
  logic                 r_dz;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_fix;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_neg;
  logic                 w_sub;
  logic [WIDTH-1:0]     w_b_eff;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_as_ovf;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_mul_last;
  logic                 w_div_finish;
  logic [WIDTH-1:0]     w_q_mag;
  logic [WIDTH-1:0]     w_r_mag;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_r;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // Magnitudes of the incoming operands; |MIN| still fits as unsigned.
  assign w_a_mag = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  assign w_neg    = r_a[WIDTH-1] ^ r_b[WIDTH-1];
  assign w_sub    = (r_func == FUNC_SUB);
  assign w_b_eff  = w_sub ? ~r_b : r_b;
  assign w_sum    = r_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_sub};
  assign w_as_ovf = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQ_ALU_EARLY_TERM_EN
  assign w_mul_last = (r_cnt == c_cnt_w'(WIDTH-1)) ||
                      (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_mul_last = (r_cnt == c_cnt_w'(WIDTH-1));
`endif

  restoring_div_core #(
    .WIDTH (WIDTH)
  ) u_div (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_start     (w_accept && (bus.func == FUNC_DIV)),
    .i_step      (r_state == DIV),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_finish    (w_div_finish),
    .o_quotient  (w_q_mag),
    .o_remainder (w_r_mag)
  );

  // Quotient takes the xor of the operand signs, remainder follows the dividend.
  assign w_q = w_neg        ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_r = r_a[WIDTH-1] ? (~w_r_mag + 1'b1) : w_r_mag;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_func   <= FUNC_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_fix    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDSUB: begin
          r_out   <= {{WIDTH{w_sum[WIDTH-1]}}, w_sum};
          r_ovf   <= w_as_ovf;
          r_dz    <= 1'b0;
          r_state <= DONE;
        end
        MUL: begin
          if (r_fix) begin
            r_out   <= w_neg ? (~r_acc + 1'b1) : r_acc;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + c_cnt_w'(1);
            r_fix    <= w_mul_last;
          end
        end
        DIV: begin
          if (r_b == '0) begin
            r_out   <= {{WIDTH{1'b1}}, r_a};
            r_ovf   <= 1'b0;
            r_dz    <= 1'b1;
            r_state <= DONE;
          end else if (w_div_finish) begin
            r_out   <= {w_q, w_r};
            r_ovf   <= (r_a == c_min) && (r_b == {WIDTH{1'b1}});
            r_dz    <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Accept only happens from IDLE/DONE, so it never races the cases above.
      if (w_accept) begin
        r_func   <= bus.func;
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_fix    <= 1'b0;
        case (bus.func)
          FUNC_MUL: r_state <= MUL;
          FUNC_DIV: r_state <= DIV;
          default:  r_state <= ADDSUB;
        endcase
      end
    end
  end

  assign bus.busy     = (r_state == ADDSUB) || (r_state == MUL) || (r_state == DIV);
  assign bus.done     = (r_state == DONE);
  assign bus.out      = r_out;
  assign bus.overflow = r_ovf;
  assign bus.div_zero = r_dz;

endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-shot signed ALU.
- Computes signed add/sub/mul/div on WIDTH-bit operands.
- Uses one shared iterative datapath: shift-add multiply and restoring divide, each one bit per cycle.
- Sits between the operand registers and the result bus. Callers issue start, then wait for done.

Parameters:
- WIDTH, 6, operand width in bits, two's complement, minimum 2. Result width is 2*WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- start  in  1  request; sampled only when busy=0
- func  in  2  00 add, 01 sub, 10 mul, 11 div
- a  in  WIDTH  signed operand / dividend
- b  in  WIDTH  signed operand / divisor
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; result valid
- out  out  2*WIDTH  signed result; div packs {quotient, remainder}
- overflow  out  1  signed overflow (add/sub, div MIN/-1)
- div_zero  out  1  division by zero

Behaviour:
- Reset (reset_n=0 at edge):
  - State goes to IDLE.
  - busy, done, overflow, div_zero and out are all 0.
  - Reset aborts any operation in flight.
- States: IDLE -> ADDSUB | MUL | DIV -> DONE -> IDLE.
  - DONE lasts exactly one cycle (done=1, busy=0).
  - A start sampled in DONE is accepted, allowing back-to-back operations.
- Accept:
  - start=1 in IDLE or DONE latches a, b and func, and sets busy=1.
  - start while busy is ignored; latched operands are unaffected.
- Latency L is measured from the accepting edge to the edge after which done=1:
  - add/sub: L=1.
  - mul/div: L=WIDTH+1 (WIDTH iterations plus a sign-fix cycle).
  - div by zero: L=1.
- out, overflow and div_zero update only when entering DONE, and hold until the next DONE or reset.
- Add/sub:
  - out[WIDTH-1:0] = wrapped WIDTH-bit result; upper bits are its sign extension.
  - overflow = signed overflow.
- Mul:
  - Operates on operand magnitudes; |MIN| = 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - Full 2*WIDTH product is negated if a[MSB]^b[MSB].
  - overflow=0.
- Div:
  - Truncating semantics, matching Verilog / and %.
  - Quotient sign = a^b; remainder sign follows a.
  - out = {q[WIDTH-1:0], r[WIDTH-1:0]}.
- Div boundaries:
  - b=0: div_zero=1, q=all ones, r=a, overflow=0.
  - a=MIN and b=-1: overflow=1, q=MIN, r=0.
- div_zero=0 for every non-div op.

Optional Feature:
- Macro SEQ_ALU_EARLY_TERM_EN.
- Defined:
  - MUL skips to the sign-fix cycle as soon as the remaining multiplier bits are zero. Latency becomes (index of highest set bit of |b| + 1) + 1, minimum 2.
  - |b|=0 gives L=2.
  - DIV is unchanged.
- Undefined: fixed latencies as specified above.

Decomposition:
- Package alu_pkg holds:
  - func codes FUNC_ADD, FUNC_SUB, FUNC_MUL, FUNC_DIV.
  - the state enum (IDLE, ADDSUB, MUL, DIV, DONE).
- One sub-module, restoring_div_core, implements the unsigned WIDTH-step iterative divider (start/step/finish). seq_alu wraps it with magnitude/sign handling.
- The multiplier stays inline.

Test Plan:
All scenarios use WIDTH=6.
- add 31+1 -> done 1 cycle after accept; out[5:0]=6'b100000 (-32); overflow=1.
- mul -32*-32 -> done 7 cycles after accept; out=12'sd1024; overflow=0. With SEQ_ALU_EARLY_TERM_EN, 3*1 completes in 2 cycles with out=3.
- div -7/2 -> done after 7 cycles; out={6'b111101, 6'b111111} (q=-3, r=-1). Also -32/-1 -> overflow=1, out={6'b100000, 6'b000000}.
- div 5/0 -> done after 1 cycle; div_zero=1; out={6'b111111, 6'b000101}.
- start pulsed mid-mul with different a/b -> ignored; original product returned. Back-to-back start during DONE is accepted.
- reset_n=0 at cycle 3 of a div -> next cycle busy=0, done=0, out=0. No done pulse follows.
- Exhaustive sweep of all 64x64 operand pairs × 4 funcs against a reference model, waiting for done each time -> 0 mismatches.
